// File: rtl/rvfi_check_pkg.sv
// Shared types, error-bit indices and helpers for the RVFI instruction checker.
// Optional PC-chain checking is enabled with RVFI_PC_CHAIN_EN.
package rvfi_check_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        DONE
    } state_t;

    localparam int ERR_RS    = 0;
    localparam int ERR_RD    = 1;
    localparam int ERR_PC    = 2;
    localparam int ERR_MEM   = 3;
    localparam int ERR_TRAP  = 4;
    localparam int ERR_CHAIN = 5;
    localparam int ERR_SPEC  = 6;
    localparam int ERR_W     = 7;

    // Equality over the low alen bits only; operands are zero-extended by callers.
    function automatic logic addr_eq(
        input logic [63:0] a,
        input logic [63:0] b,
        input int unsigned alen
    );
        logic [63:0] m;
        m = (alen >= 64) ? '1 : ((64'd1 << alen) - 64'd1);
        return ((a ^ b) & m) == '0;
    endfunction

endpackage

// File: rtl/rvfi_multi_insn_check_if.sv
// Flattened NRET-channel RVFI retirement bus; channel i at slice [i*W +: W].
// Used by rvfi_multi_insn_check (RVFI_PC_CHAIN_EN selects PC-chain checking).
interface rvfi_multi_insn_check_if #(
    parameter int NRET = 1,
    parameter int XLEN = 32,
    parameter int ILEN = 32
);
    localparam int MW = XLEN / 8;

    logic [NRET-1:0]      rvfi_valid;
    logic [NRET*ILEN-1:0] rvfi_insn;
    logic [NRET-1:0]      rvfi_trap;
    logic [NRET-1:0]      rvfi_halt;
    logic [NRET-1:0]      rvfi_intr;
    logic [NRET*5-1:0]    rvfi_rs1_addr;
    logic [NRET*5-1:0]    rvfi_rs2_addr;
    logic [NRET*5-1:0]    rvfi_rd_addr;
    logic [NRET*XLEN-1:0] rvfi_rs1_rdata;
    logic [NRET*XLEN-1:0] rvfi_rs2_rdata;
    logic [NRET*XLEN-1:0] rvfi_rd_wdata;
    logic [NRET*XLEN-1:0] rvfi_pc_rdata;
    logic [NRET*XLEN-1:0] rvfi_pc_wdata;
    logic [NRET*XLEN-1:0] rvfi_mem_addr;
    logic [NRET*MW-1:0]   rvfi_mem_rmask;
    logic [NRET*MW-1:0]   rvfi_mem_wmask;
    logic [NRET*XLEN-1:0] rvfi_mem_rdata;
    logic [NRET*XLEN-1:0] rvfi_mem_wdata;

    modport master (
        output rvfi_valid, rvfi_insn, rvfi_trap, rvfi_halt, rvfi_intr,
        output rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr,
        output rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata,
        output rvfi_pc_rdata, rvfi_pc_wdata,
        output rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask,
        output rvfi_mem_rdata, rvfi_mem_wdata
    );

    modport slave (
        input rvfi_valid, rvfi_insn, rvfi_trap, rvfi_halt, rvfi_intr,
        input rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr,
        input rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata,
        input rvfi_pc_rdata, rvfi_pc_wdata,
        input rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask,
        input rvfi_mem_rdata, rvfi_mem_wdata
    );

endinterface

// File: rtl/rvfi_chan_compare.sv
// One retirement channel against the ADDI instruction model; combinational.
// Produces a per-channel mismatch vector (chain bit is owned by the top).
module rvfi_chan_compare
    import rvfi_check_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ILEN = 32,
    parameter int ALEN = XLEN
) (
    input  logic [ILEN-1:0]   insn,
    input  logic              trap,
    input  logic [XLEN-1:0]   pc_rdata,
    input  logic [XLEN-1:0]   pc_wdata,
    input  logic [4:0]        rs1_addr,
    input  logic [4:0]        rs2_addr,
    input  logic [4:0]        rd_addr,
    input  logic [XLEN-1:0]   rs1_rdata,
    input  logic [XLEN-1:0]   rs2_rdata,
    input  logic [XLEN-1:0]   rd_wdata,
    input  logic [XLEN-1:0]   mem_addr,
    input  logic [XLEN/8-1:0] mem_rmask,
    input  logic [XLEN/8-1:0] mem_wmask,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic [XLEN-1:0]   mem_wdata,
    output logic [ERR_W-1:0]  mism
);
    localparam int MW = XLEN / 8;

    logic            spec_valid;
    logic            spec_trap;
    logic [4:0]      spec_rs1_addr;
    logic [4:0]      spec_rs2_addr;
    logic [4:0]      spec_rd_addr;
    logic [XLEN-1:0] spec_rd_wdata;
    logic [XLEN-1:0] spec_pc_wdata;
    logic [XLEN-1:0] spec_mem_addr;
    logic [XLEN-1:0] spec_mem_wdata;
    logic [MW-1:0]   spec_rmask;
    logic [MW-1:0]   spec_wmask;
    logic [XLEN-1:0] imm;
    logic            unused_rs2;

    assign unused_rs2 = ^rs2_rdata;

    assign imm            = {{(XLEN-12){insn[31]}}, insn[31:20]};
    assign spec_valid     = (insn[6:0] == 7'b0010011) && (insn[14:12] == 3'b000);
    assign spec_rs1_addr  = insn[19:15];
    assign spec_rs2_addr  = '0;
    assign spec_rd_addr   = insn[11:7];
    assign spec_rd_wdata  = (spec_rd_addr != '0) ? rs1_rdata + imm : '0;
    assign spec_pc_wdata  = pc_rdata + XLEN'(4);
    // No compressed support: any next PC off a 4-byte boundary traps.
    assign spec_trap      = spec_pc_wdata[1:0] != 2'b00;
    assign spec_mem_addr  = '0;
    assign spec_mem_wdata = '0;
    assign spec_rmask     = '0;
    assign spec_wmask     = '0;

    always_comb begin
        mism           = '0;
        mism[ERR_SPEC] = !spec_valid;
        mism[ERR_RS]   = (rs1_addr != spec_rs1_addr) ||
                         (rs2_addr != spec_rs2_addr);
        mism[ERR_TRAP] = trap != spec_trap;
        if (!spec_trap) begin
            mism[ERR_RD] = (rd_addr != spec_rd_addr) ||
                           (rd_wdata != spec_rd_wdata);
            mism[ERR_PC] = !addr_eq(64'(pc_wdata), 64'(spec_pc_wdata), ALEN);
            if ((spec_rmask | spec_wmask) != '0 &&
                !addr_eq(64'(mem_addr), 64'(spec_mem_addr), ALEN))
                mism[ERR_MEM] = 1'b1;
            for (int b = 0; b < MW; b++) begin
                if (spec_wmask[b] &&
                    (!mem_wmask[b] ||
                     mem_wdata[b*8 +: 8] != spec_mem_wdata[b*8 +: 8]))
                    mism[ERR_MEM] = 1'b1;
                // A write the model did not expect is tolerated only as an
                // observed no-op rewrite of the byte just read.
                if (!spec_wmask[b] && mem_wmask[b] &&
                    (!mem_rmask[b] ||
                     mem_rdata[b*8 +: 8] != mem_wdata[b*8 +: 8]))
                    mism[ERR_MEM] = 1'b1;
                if (spec_rmask[b] && !mem_rmask[b])
                    mism[ERR_MEM] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rvfi_multi_insn_check.sv
// Windowed multi-channel RVFI instruction checker with sticky error bits.
// Define RVFI_PC_CHAIN_EN to also check PC continuity between retirements.
module rvfi_multi_insn_check
    import rvfi_check_pkg::*;
#(
    parameter int NRET  = 1,
    parameter int XLEN  = 32,
    parameter int ILEN  = 32,
    parameter int ALEN  = XLEN,
    parameter int DEPTH = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         check_start,
    rvfi_multi_insn_check_if.slave       rvfi,
    output logic                         busy,
    output logic                         done,
    output logic [ERR_W-1:0]             err,
    output logic [$clog2(DEPTH+1)-1:0]   checked_cnt
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int MW = XLEN / 8;

    state_t           state;
    state_t           state_nx;
    logic             arm;
    logic [NRET-1:0]  sel;
    int               taken;
    logic [CW-1:0]    cnt_nx;
    logic [ERR_W-1:0] err_hit;
    logic [ERR_W-1:0] mism [NRET];
    logic             unused_ok;

    assign unused_ok = ^{rvfi.rvfi_halt, rvfi.rvfi_intr};

    for (genvar g = 0; g < NRET; g++) begin : g_chan
        rvfi_chan_compare #(
            .XLEN(XLEN),
            .ILEN(ILEN),
            .ALEN(ALEN)
        ) u_cmp (
            .insn     (rvfi.rvfi_insn[g*ILEN +: ILEN]),
            .trap     (rvfi.rvfi_trap[g]),
            .pc_rdata (rvfi.rvfi_pc_rdata[g*XLEN +: XLEN]),
            .pc_wdata (rvfi.rvfi_pc_wdata[g*XLEN +: XLEN]),
            .rs1_addr (rvfi.rvfi_rs1_addr[g*5 +: 5]),
            .rs2_addr (rvfi.rvfi_rs2_addr[g*5 +: 5]),
            .rd_addr  (rvfi.rvfi_rd_addr[g*5 +: 5]),
            .rs1_rdata(rvfi.rvfi_rs1_rdata[g*XLEN +: XLEN]),
            .rs2_rdata(rvfi.rvfi_rs2_rdata[g*XLEN +: XLEN]),
            .rd_wdata (rvfi.rvfi_rd_wdata[g*XLEN +: XLEN]),
            .mem_addr (rvfi.rvfi_mem_addr[g*XLEN +: XLEN]),
            .mem_rmask(rvfi.rvfi_mem_rmask[g*MW +: MW]),
            .mem_wmask(rvfi.rvfi_mem_wmask[g*MW +: MW]),
            .mem_rdata(rvfi.rvfi_mem_rdata[g*XLEN +: XLEN]),
            .mem_wdata(rvfi.rvfi_mem_wdata[g*XLEN +: XLEN]),
            .mism     (mism[g])
        );
    end

    // Lowest-index valid channels win until the window is full.
    always_comb begin
        sel   = '0;
        taken = 0;
        for (int i = 0; i < NRET; i++) begin
            if (state == ARMED && rvfi.rvfi_valid[i] &&
                taken < DEPTH - int'(checked_cnt)) begin
                sel[i] = 1'b1;
                taken  = taken + 1;
            end
        end
        cnt_nx = checked_cnt + CW'(taken);
    end

`ifdef RVFI_PC_CHAIN_EN
    logic            chain_v;
    logic [XLEN-1:0] chain_pc;
    logic            chain_v_nx;
    logic [XLEN-1:0] chain_pc_nx;

    always_comb begin
        err_hit     = '0;
        chain_v_nx  = chain_v;
        chain_pc_nx = chain_pc;
        for (int i = 0; i < NRET; i++) begin
            if (sel[i]) begin
                err_hit = err_hit | mism[i];
                if (chain_v_nx && !rvfi.rvfi_intr[i] &&
                    !addr_eq(64'(rvfi.rvfi_pc_rdata[i*XLEN +: XLEN]),
                             64'(chain_pc_nx), ALEN))
                    err_hit[ERR_CHAIN] = 1'b1;
                chain_v_nx  = 1'b1;
                chain_pc_nx = rvfi.rvfi_pc_wdata[i*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset || arm) begin
            chain_v  <= 1'b0;
            chain_pc <= '0;
        end else if (state == ARMED) begin
            chain_v  <= chain_v_nx;
            chain_pc <= chain_pc_nx;
        end
    end
`else
    always_comb begin
        err_hit = '0;
        for (int i = 0; i < NRET; i++)
            if (sel[i])
                err_hit = err_hit | mism[i];
    end
`endif

    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        arm      = 1'b0;
        unique case (state)
            IDLE: begin
                if (check_start) begin
                    arm      = 1'b1;
                    state_nx = ARMED;
                end
            end
            ARMED: begin
                if (cnt_nx == CW'(DEPTH)) state_nx = DONE;
            end
            DONE: begin
                if (check_start) begin
                    arm      = 1'b1;
                    state_nx = ARMED;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset || arm) begin
            checked_cnt <= '0;
            err         <= '0;
        end else if (state == ARMED) begin
            checked_cnt <= cnt_nx;
            err         <= err | err_hit;
        end
    end

    assign busy = state == ARMED;
    assign done = state == DONE;

endmodule

// File: tb/tb_rvfi_multi_insn_check.sv
// Bench for rvfi_multi_insn_check: vector table, corner sequences, random vs model.
// Expectations for err[5] follow RVFI_PC_CHAIN_EN.
module tb_rvfi_multi_insn_check;

    localparam int DEPTH = 4;

`ifdef RVFI_PC_CHAIN_EN
    localparam bit CHAIN = 1'b1;
`else
    localparam bit CHAIN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       check_start = 1'b0;
    logic       busy;
    logic       done;
    logic [6:0] err;
    logic [2:0] checked_cnt;

    rvfi_multi_insn_check_if #(.NRET(2), .XLEN(32), .ILEN(32)) rvfi ();

    rvfi_multi_insn_check #(
        .NRET(2), .XLEN(32), .ILEN(32), .ALEN(32), .DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset(reset), .check_start(check_start),
        .rvfi(rvfi), .busy(busy), .done(done), .err(err),
        .checked_cnt(checked_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        v;
        logic [31:0] insn;
        logic [4:0]  rs1a;
        logic [4:0]  rs2a;
        logic [31:0] rs1d;
        logic [4:0]  rda;
        logic [31:0] rdd;
        logic [31:0] pcr;
        logic [31:0] pcw;
        logic        trap;
        logic        intr;
        logic [3:0]  rm;
        logic [3:0]  wm;
        logic [31:0] rdat;
        logic [31:0] wdat;
    } ret_t;

    typedef struct {
        ret_t       r;
        logic [6:0] exp;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic ret_t mk(logic [31:0] insn, logic [4:0] rs1a,
                                logic [31:0] rs1d, logic [4:0] rda,
                                logic [31:0] rdd, logic [31:0] pcr,
                                logic [31:0] pcw);
        ret_t r;
        r = '{default: '0};
        r.v = 1'b1; r.insn = insn; r.rs1a = rs1a; r.rs1d = rs1d;
        r.rda = rda; r.rdd = rdd; r.pcr = pcr; r.pcw = pcw;
        return r;
    endfunction

    function automatic vec_t vv(ret_t r, logic [6:0] e);
        vec_t v;
        v.r = r;
        v.exp = e;
        return v;
    endfunction

    task automatic put(int ch, ret_t r);
        rvfi.rvfi_valid[ch]              = r.v;
        rvfi.rvfi_insn[ch*32 +: 32]      = r.insn;
        rvfi.rvfi_trap[ch]               = r.trap;
        rvfi.rvfi_halt[ch]               = 1'b0;
        rvfi.rvfi_intr[ch]               = r.intr;
        rvfi.rvfi_rs1_addr[ch*5 +: 5]    = r.rs1a;
        rvfi.rvfi_rs2_addr[ch*5 +: 5]    = r.rs2a;
        rvfi.rvfi_rd_addr[ch*5 +: 5]     = r.rda;
        rvfi.rvfi_rs1_rdata[ch*32 +: 32] = r.rs1d;
        rvfi.rvfi_rs2_rdata[ch*32 +: 32] = 32'h0;
        rvfi.rvfi_rd_wdata[ch*32 +: 32]  = r.rdd;
        rvfi.rvfi_pc_rdata[ch*32 +: 32]  = r.pcr;
        rvfi.rvfi_pc_wdata[ch*32 +: 32]  = r.pcw;
        rvfi.rvfi_mem_addr[ch*32 +: 32]  = 32'h0;
        rvfi.rvfi_mem_rmask[ch*4 +: 4]   = r.rm;
        rvfi.rvfi_mem_wmask[ch*4 +: 4]   = r.wm;
        rvfi.rvfi_mem_rdata[ch*32 +: 32] = r.rdat;
        rvfi.rvfi_mem_wdata[ch*32 +: 32] = r.wdat;
    endtask

    task automatic clr();
        ret_t z;
        z = '{default: '0};
        put(0, z);
        put(1, z);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic arm();
        check_start = 1'b1;
        tick();
        check_start = 1'b0;
    endtask

    function automatic logic [6:0] fexp(int f);
        unique case (f)
            5:       return 7'h02;
            6:       return 7'h04;
            7:       return 7'h01;
            8:       return 7'h10;
            9:       return 7'h08;
            10:      return 7'h40;
            default: return 7'h00;
        endcase
    endfunction

    ret_t g;
    ret_t t;
    ret_t rr[2];
    int   ff[2];
    vec_t vecs[$];

    int          m_cnt;
    logic [6:0]  m_err;
    logic        m_busy;
    logic        m_done;
    logic        m_lastv;
    logic [31:0] m_lastpc;
    logic [31:0] gen_pc;

    initial begin
        clr();
        g = mk(32'h00500093, 5'd0, 32'h0, 5'd1, 32'h5, 32'h100, 32'h104);

        vecs.push_back(vv(g, 7'h00));
        t = g; t.rdd = 32'h6;              vecs.push_back(vv(t, 7'h02));
        t = g; t.pcw = 32'h108;            vecs.push_back(vv(t, 7'h04));
        t = g; t.rs1a = 5'd3;              vecs.push_back(vv(t, 7'h01));
        t = g; t.insn = 32'h00501093;      vecs.push_back(vv(t, 7'h40));
        t = g; t.trap = 1'b1;              vecs.push_back(vv(t, 7'h10));
        t = g; t.pcr = 32'h102; t.pcw = 32'h106;
        vecs.push_back(vv(t, 7'h10));
        t.trap = 1'b1; t.rdd = 32'h99;     vecs.push_back(vv(t, 7'h00));
        vecs.push_back(vv(mk(32'h00508093, 5'd1, 32'h10, 5'd1, 32'h15,
                             32'h100, 32'h104), 7'h00));
        t = mk(32'h00500013, 5'd0, 32'h0, 5'd0, 32'h0, 32'h100, 32'h104);
        vecs.push_back(vv(t, 7'h00));
        t.rdd = 32'h5;                     vecs.push_back(vv(t, 7'h02));
        vecs.push_back(vv(mk(32'hfff00093, 5'd0, 32'h0, 5'd1, 32'hffffffff,
                             32'h100, 32'h104), 7'h00));
        vecs.push_back(vv(mk(32'hfff00093, 5'd0, 32'h7, 5'd1, 32'h6,
                             32'h100, 32'h104), 7'h00));
        t = g; t.wm = 4'h1;                vecs.push_back(vv(t, 7'h08));
        t.rm = 4'h1; t.rdat = 32'hab; t.wdat = 32'hab;
        vecs.push_back(vv(t, 7'h00));
        t.wdat = 32'hac;                   vecs.push_back(vv(t, 7'h08));
        t = g; t.rm = 4'hf;                vecs.push_back(vv(t, 7'h00));
        t = g; t.rdd = 32'h6; t.pcw = 32'h108;
        vecs.push_back(vv(t, 7'h06));
        t = g; t.rda = 5'd2;               vecs.push_back(vv(t, 7'h02));
        t = g; t.rs2a = 5'd2;              vecs.push_back(vv(t, 7'h01));

        tick();
        do_reset();
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_cnt", 32'(checked_cnt), 32'h0);

        foreach (vecs[i]) begin
            do_reset();
            arm();
            chk($sformatf("v%0d_busy", i), 32'(busy), 32'h1);
            put(0, vecs[i].r);
            tick();
            clr();
            chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].exp));
            chk($sformatf("v%0d_cnt", i), 32'(checked_cnt), 32'h1);
        end

        // Sticky error, then ignored re-arm while armed.
        do_reset();
        arm();
        t = g; t.rdd = 32'h6;
        put(0, t); tick(); clr();
        chk("sticky_a", 32'(err), 32'h02);
        tick();
        chk("sticky_b", 32'(err), 32'h02);
        t = g; t.pcr = 32'h104; t.pcw = 32'h108;
        check_start = 1'b1;
        put(0, t); tick(); clr();
        check_start = 1'b0;
        chk("sticky_c", 32'(err), 32'h02);
        chk("rearm_ignored_cnt", 32'(checked_cnt), 32'h2);

        // Saturation: only ch0 fits, bad ch1 must not be checked.
        do_reset();
        arm();
        for (int k = 0; k < 3; k++) begin
            t = g; t.pcr = 32'h100 + 32'(4*k); t.pcw = t.pcr + 32'h4;
            put(0, t); tick();
        end
        t = g; t.pcr = 32'h10c; t.pcw = 32'h110; put(0, t);
        t = g; t.pcr = 32'h110; t.pcw = 32'h114; t.rdd = 32'h6; put(1, t);
        tick(); clr();
        chk("sat_cnt", 32'(checked_cnt), 32'h4);
        chk("sat_done", 32'(done), 32'h1);
        chk("sat_busy", 32'(busy), 32'h0);
        chk("sat_err", 32'(err), 32'h0);
        t = g; t.rdd = 32'h6; put(0, t); tick(); clr();
        chk("done_noerr", 32'(err), 32'h0);
        chk("done_cnt", 32'(checked_cnt), 32'h4);
        arm();
        chk("rearm_cnt", 32'(checked_cnt), 32'h0);
        chk("rearm_busy", 32'(busy), 32'h1);

        // Chain break across cycles.
        do_reset();
        arm();
        put(0, g); tick();
        t = g; t.pcr = 32'h108; t.pcw = 32'h10c; put(0, t); tick(); clr();
        chk("chain_break", 32'(err), CHAIN ? 32'h20 : 32'h0);

        // In-cycle chaining, intr exemption, then an in-cycle break.
        do_reset();
        arm();
        put(0, g);
        t = g; t.pcr = 32'h104; t.pcw = 32'h108; put(1, t);
        tick();
        t = g; t.pcr = 32'h200; t.pcw = 32'h204; t.intr = 1'b1; put(0, t);
        t = g; t.pcr = 32'h204; t.pcw = 32'h208; put(1, t);
        tick(); clr();
        chk("chain_ok_err", 32'(err), 32'h0);
        chk("chain_ok_done", 32'(done), 32'h1);
        arm();
        put(0, g);
        t = g; t.pcr = 32'h200; t.pcw = 32'h204; put(1, t);
        tick(); clr();
        chk("chain_incyc", 32'(err), CHAIN ? 32'h20 : 32'h0);

        // Reset mid-window.
        do_reset();
        arm();
        put(0, g); tick();
        t = g; t.pcr = 32'h104; t.pcw = 32'h108; put(0, t); tick(); clr();
        chk("mid_cnt2", 32'(checked_cnt), 32'h2);
        do_reset();
        chk("mid_cnt", 32'(checked_cnt), 32'h0);
        chk("mid_busy", 32'(busy), 32'h0);
        t = g; t.rdd = 32'h6; put(0, t); tick(); clr();
        chk("mid_ign_cnt", 32'(checked_cnt), 32'h0);
        chk("mid_ign_err", 32'(err), 32'h0);
        arm();
        chk("mid_arm_busy", 32'(busy), 32'h1);

        // Random traffic against a window-level model.
        do_reset();
        m_cnt = 0; m_err = '0; m_busy = 1'b0; m_done = 1'b0;
        m_lastv = 1'b0; m_lastpc = '0;
        gen_pc = 32'h1000;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            reset = ($urandom_range(0, 99) != 0);
            check_start = ($urandom_range(0, 5) == 0);
            for (int c = 0; c < 2; c++) begin
                logic [4:0]  rd;
                logic [4:0]  rs;
                logic [11:0] imm;
                rd  = 5'($urandom_range(0, 31));
                rs  = 5'($urandom_range(0, 31));
                imm = 12'($urandom_range(0, 4095));
                rr[c] = mk({imm, rs, 3'b000, rd, 7'b0010011}, rs, $urandom,
                           rd, 32'h0, gen_pc, gen_pc + 32'h4);
                if ($urandom_range(0, 7) == 0) begin
                    rr[c].pcr = $urandom & 32'hfffffffc;
                    rr[c].pcw = rr[c].pcr + 32'h4;
                end
                rr[c].rdd = (rd == 5'd0) ? 32'h0 :
                            rr[c].rs1d + {{20{imm[11]}}, imm};
                rr[c].intr = ($urandom_range(0, 15) == 0);
                ff[c] = $urandom_range(0, 10);
                unique case (ff[c])
                    5:  rr[c].rdd = rr[c].rdd + 32'h1;
                    6:  rr[c].pcw = rr[c].pcr + 32'h8;
                    7:  rr[c].rs1a = rr[c].rs1a ^ 5'd1;
                    8:  rr[c].trap = 1'b1;
                    9:  rr[c].wm = 4'($urandom_range(1, 15));
                    10: rr[c].insn[14:12] = 3'b010;
                    default: ;
                endcase
                rr[c].v = ($urandom_range(0, 9) < 6);
                if (rr[c].v) gen_pc = rr[c].pcw;
                put(c, rr[c]);
            end
            if (!reset) begin
                m_cnt = 0; m_err = '0; m_busy = 1'b0; m_done = 1'b0;
                m_lastv = 1'b0;
            end else if (m_busy) begin
                for (int c = 0; c < 2; c++) begin
                    if (rr[c].v && m_cnt < DEPTH) begin
                        logic [6:0] e;
                        e = fexp(ff[c]);
                        if (CHAIN && m_lastv && !rr[c].intr &&
                            rr[c].pcr != m_lastpc)
                            e[5] = 1'b1;
                        m_lastv  = 1'b1;
                        m_lastpc = rr[c].pcw;
                        m_err    = m_err | e;
                        m_cnt++;
                    end
                end
                if (m_cnt == DEPTH) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end
            end else if (check_start) begin
                m_busy = 1'b1; m_done = 1'b0; m_cnt = 0; m_err = '0;
                m_lastv = 1'b0;
            end
            tick();
            chk($sformatf("r%0d_cnt", cyc), 32'(checked_cnt), 32'(m_cnt));
            chk($sformatf("r%0d_err", cyc), 32'(err), 32'(m_err));
            chk($sformatf("r%0d_busy", cyc), 32'(busy), 32'(m_busy));
            chk($sformatf("r%0d_done", cyc), 32'(done), 32'(m_done));
        end
        reset = 1'b1;
        check_start = 1'b0;
        clr();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rvfi_multi_insn_check.md
# rvfi_multi_insn_check

Sequential, parametrised instruction checker for the formal/simulation harness. It sits between the core's RVFI retirement bus and the instruction-model library. It is armed by a start pulse, then checks the next DEPTH retirements across all NRET channels in channel order against the selected instruction model. Optionally, it also verifies PC continuity between consecutive checked retirements. Mismatches are reported as sticky, registered error bits that the harness asserts to be zero.

## Interface
- NRET, 1: number of RVFI retirement channels.
- XLEN, 32: register/address width.
- ILEN, 32: instruction width.
- ALEN, XLEN: number of low address bits compared for PC and memory-address checks (ALEN ≤ XLEN).
- DEPTH, 8: number of retirements checked per armed window (≥ 1).
- clock  in  1  rising-edge clock.
- reset  in  1  reset, synchronous, active-low.
- check_start  in  1  arms a check window.
- rvfi_*  in  NRET×field  flattened RVFI bus, channel i at slice [i*W +: W]: valid, insn, trap, halt, intr, rs1/rs2/rd_addr, rs1/rs2_rdata, rd_wdata, pc_rdata/wdata, mem_addr/rmask/wmask/rdata/wdata.
- busy  out  1  window armed.
- done  out  1  window complete; held until next arm.
- err  out  7  sticky error vector:
  - [0] rs1/rs2 address
  - [1] rd address/data
  - [2] pc_wdata
  - [3] memory
  - [4] trap mismatch
  - [5] PC chain
  - [6] spec_valid low (unsupported instruction)
- checked_cnt  out  $clog2(DEPTH+1)  retirements checked in the current window.

## Operation
- FSM states IDLE, ARMED, DONE.
  - IDLE → ARMED on check_start.
  - ARMED → DONE when checked_cnt reaches DEPTH.
  - DONE → ARMED on check_start, which clears checked_cnt and err.
- check_start while ARMED is ignored.
- Per cycle in ARMED, let rem = DEPTH − checked_cnt.
  - The valid channels with the lowest indices, up to rem of them, are selected.
  - Higher-index valid channels beyond rem are not checked.
  - checked_cnt += number of selected channels; it never exceeds DEPTH.
- Per selected channel, the spec model is driven with insn, pc_rdata, rs1/rs2_rdata and mem_rdata. The following checks apply:
  - spec_valid low → err[6].
  - rs1/rs2 address mismatch → err[0], checked even when trapping.
  - trap ≠ spec_trap → err[4].
  - When spec_trap is low:
    - rd_addr or rd_wdata mismatch → err[1].
    - pc_wdata low-ALEN-bit mismatch → err[2].
    - err[3] is set on any of the following:
      - mem_addr low-ALEN-bit mismatch while any spec mask bit is set;
      - a spec_wmask byte whose rvfi wmask bit is clear or whose wdata byte differs;
      - an rvfi-only wmask byte that has no rmask bit or whose rdata byte ≠ wdata byte;
      - a spec_rmask byte without the matching rvfi rmask bit.
- Unselected channels and cycles outside ARMED never set err bits.
- err bits only OR in; they clear only on reset or re-arm.

## Timing
- Reset values: state = IDLE, busy = 0, done = 0, err = 0, checked_cnt = 0; PC-chain register invalid.
- busy rises in the cycle after check_start is sampled.
- A retirement is checked in the cycle it is valid. The resulting err bits and checked_cnt are visible the following cycle.
- done rises in the cycle after the DEPTH-th check and busy falls in that same cycle.
- Reset asserted mid-window returns to IDLE and discards all progress.

## Configuration
- RVFI_PC_CHAIN_EN defined:
  - A register holds the pc_wdata of the last checked retirement and a valid bit. Both are cleared on arm and on reset.
  - Each selected retirement without intr set must have pc_rdata equal that value in the low ALEN bits; otherwise err[5] is set.
  - Chaining within a cycle proceeds channel i−1 → i combinationally.
  - The first check of a window is exempt.
- RVFI_PC_CHAIN_EN undefined: no chain register; err[5] is tied to 0.

## Structure
- Shared package rvfi_check_pkg holds:
  - the state enum;
  - the err bit-index localparams (ERR_RS, ERR_RD, ERR_PC, ERR_MEM, ERR_TRAP, ERR_CHAIN, ERR_SPEC);
  - the masked address-compare function.
- Sub-module rvfi_chan_compare: one instance per channel, generate loop. It wraps the macro-selected instruction model and produces a 7-bit combinational per-channel mismatch vector. The top level holds the FSM, selection, counter, chain register and sticky errors.

## Test plan
All scenarios use NRET=2, XLEN=32, DEPTH=4, with the ADDI model.
- Correct retirement:
  - Stimulus: arm; ch0 valid, insn 32'h00500093, rs1_rdata 0, rd_addr 1, rd_wdata 5, pc 0x100 → 0x104.
  - Response: next cycle checked_cnt = 1, err = 0.
- Wrong result: same stimulus with rd_wdata 6 → err[1] set next cycle and stays set until re-arm.
- Saturation at window end:
  - Stimulus: after 3 checks, ch0 and ch1 both valid, ch1 carrying a bad rd_wdata.
  - Response: checked_cnt = 4, done = 1, busy = 0, err = 0.
- PC chain break: pc_wdata 0x104 followed by pc_rdata 0x108.
  - With RVFI_PC_CHAIN_EN defined → err[5] = 1.
  - Without it → err = 0.
- Reset mid-window: reset low for one cycle while ARMED with checked_cnt = 2 → IDLE, checked_cnt = 0, busy = 0. Later retirements are ignored until check_start.
